// File: rtl/mm2s_frame_sched_pkg.sv
// Shared types and helpers for the mm2s frame scheduler.
// The state enum, the buffer-count limit and the index-width helper live here.
package mm2s_frame_sched_pkg;

   typedef enum logic [1:0] {
      STOPPED = 2'd0,
      RUN     = 2'd1,
      DRAIN   = 2'd2
   } state_t;

   localparam int C_MAX_BUF = 4;

   // Smallest index width that can name n buffers.
   function automatic int idx_bits(input int n);
      for (int b = 1; b < 32; b++) begin
         if ((1 << b) >= n) return b;
      end
      return 32;
   endfunction

endpackage

// File: rtl/mm2s_buf_picker.sv
// Picks the read buffer on a frame pulse and muxes its base address; purely combinational.
// Zero latency, no backpressure: w_done on an out-of-range index counts as no completion.
module mm2s_buf_picker
   import mm2s_frame_sched_pkg::*;
#(
   parameter int C_BUF_NUM          = 3,
   parameter int C_IDX_BITS         = 2,
   parameter int C_M_AXI_ADDR_WIDTH = 32
) (
   input  logic [C_BUF_NUM*C_M_AXI_ADDR_WIDTH-1:0] i_buf_addrs,
   input  logic [C_IDX_BITS-1:0]                   i_w_idx,
   input  logic                                    i_w_done,
   input  logic [C_IDX_BITS-1:0]                   i_latest_idx,
   input  logic                                    i_latest_valid,
   input  logic [C_IDX_BITS-1:0]                   i_cur_idx,
   input  logic                                    i_pick,
   output logic                                    o_w_ok,
   output logic                                    o_accept,
   output logic [C_IDX_BITS-1:0]                   o_sel_idx,
   output logic [C_M_AXI_ADDR_WIDTH-1:0]           o_addr
);

   localparam logic [C_IDX_BITS:0] C_NUM_L = (C_IDX_BITS+1)'(C_BUF_NUM);

   logic [C_IDX_BITS-1:0] w_cand;
   logic                  w_cvalid;

   assign o_w_ok   = i_w_done && ({1'b0, i_w_idx} < C_NUM_L);
   assign w_cand   = o_w_ok ? i_w_idx : i_latest_idx;
   assign w_cvalid = o_w_ok | i_latest_valid;
   // Never hand the reader the buffer the writer is filling right now.
   assign o_accept  = i_pick && w_cvalid && (w_cand != i_w_idx);
   assign o_sel_idx = o_accept ? w_cand : i_cur_idx;

   always_comb begin
      o_addr = '0;
      for (int k = 0; k < C_BUF_NUM; k++) begin
         if (o_sel_idx == C_IDX_BITS'(k)) o_addr = i_buf_addrs[k*C_M_AXI_ADDR_WIDTH +: C_M_AXI_ADDR_WIDTH];
      end
   end

endmodule

// File: rtl/mm2s_frame_sched.sv
// Frame controller for the mm2s reader: soft-reset sequencing, fsync gating, newest-complete buffer pick.
// fsync/r_addr are zero-latency; state changes land one clock later. MM2S_FRAME_SCHED_STATS_EN adds counters.
module mm2s_frame_sched
   import mm2s_frame_sched_pkg::*;
#(
   parameter int C_BUF_NUM          = 3,
   parameter int C_IDX_BITS         = 2,
   parameter int C_M_AXI_ADDR_WIDTH = 32,
   parameter int C_CNT_BITS         = 16
) (
   input  logic                                    clk,
   input  logic                                    resetn,
   input  logic                                    enable,
   input  logic                                    fsync,
   input  logic [C_BUF_NUM*C_M_AXI_ADDR_WIDTH-1:0] buf_addrs,
   input  logic [C_IDX_BITS-1:0]                   w_idx,
   input  logic                                    w_done,
   output logic                                    mm2s_soft_resetn,
   input  logic                                    mm2s_resetting,
   output logic                                    mm2s_fsync,
   input  logic                                    r_sof,
   output logic [C_M_AXI_ADDR_WIDTH-1:0]           r_addr,
   output logic [C_IDX_BITS-1:0]                   r_idx,
   output logic                                    running,
   output logic [C_CNT_BITS-1:0]                   frames_read,
   output logic [C_CNT_BITS-1:0]                   frames_repeated
);

   generate
      if (idx_bits(C_BUF_NUM) > C_IDX_BITS || C_BUF_NUM > C_MAX_BUF || C_BUF_NUM < 2) begin : g_bad_cfg
         illegal_mm2s_frame_sched_parameters u_bad ();
      end
   endgenerate

   state_t                r_state, w_state_nxt;
   logic [C_IDX_BITS-1:0] r_latest_idx;
   logic                  r_latest_valid;
   logic [C_IDX_BITS-1:0] r_rd_idx;

   logic                  w_pick;
   logic                  w_w_ok;
   logic                  w_accept;
   logic [C_IDX_BITS-1:0] w_sel_idx;

   assign w_pick = r_sof && (r_state == RUN);

   mm2s_buf_picker #(
      .C_BUF_NUM          (C_BUF_NUM),
      .C_IDX_BITS         (C_IDX_BITS),
      .C_M_AXI_ADDR_WIDTH (C_M_AXI_ADDR_WIDTH)
   ) u_picker (
      .i_buf_addrs    (buf_addrs),
      .i_w_idx        (w_idx),
      .i_w_done       (w_done),
      .i_latest_idx   (r_latest_idx),
      .i_latest_valid (r_latest_valid),
      .i_cur_idx      (r_rd_idx),
      .i_pick         (w_pick),
      .o_w_ok         (w_w_ok),
      .o_accept       (w_accept),
      .o_sel_idx      (w_sel_idx),
      .o_addr         (r_addr)
   );

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) r_state <= STOPPED;
      else         r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt      = r_state;
      mm2s_soft_resetn = 1'b0;
      running          = 1'b0;
      mm2s_fsync       = 1'b0;
      case (r_state)
         STOPPED: if (enable && !mm2s_resetting) w_state_nxt = RUN;
         RUN: begin
            mm2s_soft_resetn = 1'b1;
            running          = 1'b1;
            mm2s_fsync       = fsync;
            if (!enable) w_state_nxt = DRAIN;
         end
         DRAIN:   if (!mm2s_resetting) w_state_nxt = STOPPED;
         default: w_state_nxt = STOPPED;
      endcase
   end

   // A same-cycle completion is always rejected by the picker, so it never races a clear.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_latest_idx   <= '0;
         r_latest_valid <= 1'b0;
         r_rd_idx       <= '0;
      end else begin
         if (w_w_ok) begin
            r_latest_idx   <= w_idx;
            r_latest_valid <= 1'b1;
         end else if (w_accept) begin
            r_latest_valid <= 1'b0;
         end
         if (w_accept) r_rd_idx <= w_sel_idx;
      end
   end

   assign r_idx = r_rd_idx;

`ifdef MM2S_FRAME_SCHED_STATS_EN
   logic [C_CNT_BITS-1:0] r_frames_read;
   logic [C_CNT_BITS-1:0] r_frames_rep;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_frames_read <= '0;
         r_frames_rep  <= '0;
      end else if (w_pick) begin
         if (w_accept) begin
            if (r_frames_read != '1) r_frames_read <= r_frames_read + 1'b1;
         end else begin
            if (r_frames_rep != '1) r_frames_rep <= r_frames_rep + 1'b1;
         end
      end
   end

   assign frames_read     = r_frames_read;
   assign frames_repeated = r_frames_rep;
`else
   assign frames_read     = '0;
   assign frames_repeated = '0;
`endif

endmodule

// File: tb/tb_mm2s_frame_sched.sv
// Bench for mm2s_frame_sched: directed scenarios plus randomized traffic against a frame-level model.
module tb_mm2s_frame_sched;

   localparam int NB = 3;
   localparam int IW = 2;
   localparam int AW = 32;
   localparam int CW = 16;
`ifdef MM2S_FRAME_SCHED_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   logic           clk = 1'b0;
   logic           resetn;
   logic           enable;
   logic           fsync;
   logic [NB*AW-1:0] buf_addrs;
   logic [IW-1:0]  w_idx;
   logic           w_done;
   logic           mm2s_soft_resetn;
   logic           mm2s_resetting;
   logic           mm2s_fsync;
   logic           r_sof;
   logic [AW-1:0]  r_addr;
   logic [IW-1:0]  r_idx;
   logic           running;
   logic [CW-1:0]  frames_read;
   logic [CW-1:0]  frames_repeated;

   int checks   = 0;
   int failures = 0;

   // Reference model: what software would observe, kept as plain flags and numbers.
   bit          m_run, m_drain;
   bit          m_have_new;
   int          m_newest;
   int          m_reading;
   int          m_reads, m_reps;
   logic [AW-1:0] addrs [NB];

   always #5 clk = ~clk;

   mm2s_frame_sched #(
      .C_BUF_NUM(NB), .C_IDX_BITS(IW), .C_M_AXI_ADDR_WIDTH(AW), .C_CNT_BITS(CW)
   ) dut (
      .clk(clk), .resetn(resetn), .enable(enable), .fsync(fsync), .buf_addrs(buf_addrs),
      .w_idx(w_idx), .w_done(w_done), .mm2s_soft_resetn(mm2s_soft_resetn),
      .mm2s_resetting(mm2s_resetting), .mm2s_fsync(mm2s_fsync), .r_sof(r_sof),
      .r_addr(r_addr), .r_idx(r_idx), .running(running),
      .frames_read(frames_read), .frames_repeated(frames_repeated)
   );

   function automatic void model_reset();
      m_run = 0; m_drain = 0; m_have_new = 0; m_newest = 0;
      m_reading = 0; m_reads = 0; m_reps = 0;
   endfunction

   function automatic void set_addrs(input logic [AW-1:0] a0, a1, a2);
      addrs[0] = a0; addrs[1] = a1; addrs[2] = a2;
      buf_addrs = {a2, a1, a0};
   endfunction

   // One clock: drive after the falling edge, check combinational outputs, then registered ones.
   task automatic do_cycle(input bit en, fs, wd, input int wi, input bit sof, busy);
      bit done_ok, pick, switch_buf;
      int want;
      int exp_fr, exp_rep;
      enable = en; fsync = fs; w_done = wd; w_idx = IW'(wi); r_sof = sof; mm2s_resetting = busy;
      #1;
      done_ok = wd && (wi < NB);
      pick    = m_run && sof;
      want    = done_ok ? wi : m_newest;
      switch_buf = pick && (done_ok || m_have_new) && (want != wi);
      checks++;
      if (mm2s_fsync !== (fs && m_run)) begin
         failures++;
         $display("FAIL fsync_gate: got %b want %b", mm2s_fsync, fs && m_run);
      end
      checks++;
      if (r_addr !== addrs[switch_buf ? want : m_reading]) begin
         failures++;
         $display("FAIL r_addr_same_cycle: got %h want %h", r_addr, addrs[switch_buf ? want : m_reading]);
      end
      @(posedge clk);
      if (done_ok) begin
         m_newest = wi; m_have_new = 1;
      end else if (switch_buf) begin
         m_have_new = 0;
      end
      if (switch_buf) m_reading = want;
      if (pick) begin
         if (switch_buf) m_reads = (m_reads == 65535) ? 65535 : m_reads + 1;
         else            m_reps  = (m_reps  == 65535) ? 65535 : m_reps + 1;
      end
      if (m_run) begin
         if (!en) begin m_run = 0; m_drain = 1; end
      end else if (m_drain) begin
         if (!busy) m_drain = 0;
      end else if (en && !busy) begin
         m_run = 1;
      end
      @(negedge clk);
      exp_fr  = STATS ? m_reads : 0;
      exp_rep = STATS ? m_reps  : 0;
      checks++;
      if (r_idx !== IW'(m_reading)) begin
         failures++;
         $display("FAIL r_idx: got %0d want %0d", r_idx, m_reading);
      end
      checks++;
      if (running !== m_run || mm2s_soft_resetn !== m_run) begin
         failures++;
         $display("FAIL run_state: running=%b soft_resetn=%b want %b", running, mm2s_soft_resetn, m_run);
      end
      checks++;
      if (frames_read !== CW'(exp_fr) || frames_repeated !== CW'(exp_rep)) begin
         failures++;
         $display("FAIL counters: read=%0d rep=%0d want %0d/%0d", frames_read, frames_repeated, exp_fr, exp_rep);
      end
   endtask

   task automatic test_reset();
      resetn = 1'b0; enable = 1'b1; fsync = 1'b1;
      #1;
      checks++;
      if (mm2s_soft_resetn !== 1'b0 || running !== 1'b0 || mm2s_fsync !== 1'b0) begin
         failures++;
         $display("FAIL reset_ctrl: soft=%b run=%b fsync=%b want 0/0/0", mm2s_soft_resetn, running, mm2s_fsync);
      end
      checks++;
      if (r_idx !== '0 || r_addr !== addrs[0] || frames_read !== '0 || frames_repeated !== '0) begin
         failures++;
         $display("FAIL reset_data: idx=%0d addr=%h rd=%0d rep=%0d want 0/%h/0/0", r_idx, r_addr, frames_read, frames_repeated, addrs[0]);
      end
      @(negedge clk);
      enable = 1'b0; fsync = 1'b0;
      resetn = 1'b1;
      model_reset();
   endtask

   task automatic test_startup();
      do_cycle(0, 1, 0, 0, 0, 0);          // fsync while stopped must not reach the reader
      do_cycle(1, 0, 0, 0, 0, 0);
      checks++;
      if (running !== 1'b1 || mm2s_soft_resetn !== 1'b1) begin
         failures++;
         $display("FAIL startup_run: running=%b soft=%b want 1/1", running, mm2s_soft_resetn);
      end
      do_cycle(1, 1, 0, 0, 0, 0);
   endtask

   task automatic test_normal_pick();
      do_cycle(1, 0, 1, 1, 0, 0);
      do_cycle(1, 0, 0, 2, 0, 0);
      do_cycle(1, 0, 0, 2, 1, 0);
      checks++;
      if (r_idx !== 2'd1 || r_addr !== 32'h2000) begin
         failures++;
         $display("FAIL normal_pick: idx=%0d addr=%h want 1/00002000", r_idx, r_addr);
      end
   endtask

   task automatic test_repeat();
      do_cycle(1, 0, 0, 2, 1, 0);
      checks++;
      if (r_idx !== 2'd1) begin
         failures++;
         $display("FAIL repeat_pick: idx=%0d want 1", r_idx);
      end
   endtask

   task automatic test_collision();
      do_cycle(1, 0, 1, 2, 0, 0);
      do_cycle(1, 0, 0, 2, 1, 0);
      checks++;
      if (r_idx !== 2'd1) begin
         failures++;
         $display("FAIL collision: idx=%0d want 1", r_idx);
      end
   endtask

   task automatic test_same_cycle();
      do_cycle(1, 0, 1, 0, 1, 0);
      checks++;
      if (r_idx !== 2'd1) begin
         failures++;
         $display("FAIL same_cycle_reject: idx=%0d want 1", r_idx);
      end
      do_cycle(1, 0, 0, 1, 1, 0);
      checks++;
      if (r_idx !== 2'd0 || r_addr !== 32'h1000) begin
         failures++;
         $display("FAIL same_cycle_retained: idx=%0d addr=%h want 0/00001000", r_idx, r_addr);
      end
   endtask

   task automatic test_out_of_range();
      do_cycle(1, 0, 1, 3, 0, 0);
      do_cycle(1, 0, 0, 1, 1, 0);
      checks++;
      if (r_idx !== 2'd0) begin
         failures++;
         $display("FAIL out_of_range_drop: idx=%0d want 0", r_idx);
      end
   endtask

   task automatic test_stop_restart();
      int drain_cycles = 0;
      do_cycle(1, 0, 1, 2, 0, 0);
      for (int i = 0; i < 5; i++) begin
         do_cycle(i > 1, 1, 0, 1, 1, 1);   // enable and r_sof during drain are ignored
         if (!running && !mm2s_soft_resetn && m_drain) drain_cycles++;
      end
      checks++;
      if (drain_cycles != 5) begin
         failures++;
         $display("FAIL drain_hold: drained %0d cycles want 5", drain_cycles);
      end
      do_cycle(1, 0, 0, 1, 0, 0);
      checks++;
      if (running !== 1'b0) begin
         failures++;
         $display("FAIL drain_to_stopped: running=%b want 0", running);
      end
      do_cycle(1, 0, 0, 1, 0, 0);
      do_cycle(1, 0, 0, 1, 1, 0);
      checks++;
      if (r_idx !== 2'd2) begin
         failures++;
         $display("FAIL restart_pick: idx=%0d want 2", r_idx);
      end
   endtask

   task automatic test_random();
      set_addrs($urandom, $urandom, $urandom);
      for (int i = 0; i < 400; i++) begin
         do_cycle(($urandom % 12) != 0, $urandom % 2, ($urandom % 3) == 0,
                  int'($urandom % 4), ($urandom % 3) == 0, ($urandom % 4) == 0);
      end
   endtask

   task automatic test_async_reset();
      do_cycle(1, 0, 0, 0, 0, 0);
      do_cycle(1, 0, 0, 0, 0, 0);
      fsync = 1'b1;
      #2 resetn = 1'b0;
      #1;
      checks++;
      if (mm2s_soft_resetn !== 1'b0 || running !== 1'b0 || mm2s_fsync !== 1'b0 || r_idx !== '0
          || frames_read !== '0 || frames_repeated !== '0) begin
         failures++;
         $display("FAIL async_reset: soft=%b run=%b fs=%b idx=%0d rd=%0d rep=%0d want all 0",
                  mm2s_soft_resetn, running, mm2s_fsync, r_idx, frames_read, frames_repeated);
      end
      @(negedge clk);
      fsync = 1'b0; enable = 1'b0;
      resetn = 1'b1;
      model_reset();
      do_cycle(1, 0, 0, 0, 0, 0);
   endtask

   initial begin
      resetn = 1'b0; enable = 1'b0; fsync = 1'b0; w_idx = '0; w_done = 1'b0;
      r_sof = 1'b0; mm2s_resetting = 1'b0;
      set_addrs(32'h1000, 32'h2000, 32'h3000);
      model_reset();
      repeat (2) @(negedge clk);
      test_reset();
      test_startup();
      test_normal_pick();
      test_repeat();
      test_collision();
      test_same_cycle();
      test_out_of_range();
      test_stop_restart();
      test_random();
      test_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
